wb_commit_stage: RTL and testbench

Parametrised writeback/commit stage for the MIPS pipeline, sitting between MEM and the register file/CP0. It retires instructions through a valid/allowin handshake and commits precise exceptions, eret and interrupts with a single-cycle pipeline flush. Optionally it spends an extra cycle on mfc0 to register CP0 read data, and it keeps a retired-instruction counter.

---
 rtl/wb_commit_stage.sv | 183 ++++++++++++++++++
 tb/tb_wb_commit_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: retires MEM results into the GPR file and CP0, and
// commits exceptions, interrupts and eret with a single-cycle pipeline flush.
module wb_commit_stage #(
  parameter int DW            = 32,
  parameter int RAW           = 5,
  parameter int ECW           = 5,
  parameter int CAW           = 8,
  parameter int PIPE_CP0_READ = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_to_ws_valid,
  output logic             ws_allowin,
  input  logic [DW-1:0]    ms_pc,
  input  logic [DW-1:0]    ms_result,
  input  logic             ms_gr_we,
  input  logic [RAW-1:0]   ms_dest,
  input  logic [DW-1:0]    ms_rt_value,
  input  logic [CAW-1:0]   ms_cp0_addr,
  input  logic             ms_op_mfc0,
  input  logic             ms_op_mtc0,
  input  logic             ms_op_eret,
  input  logic             ms_excp,
  input  logic [ECW-1:0]   ms_excode,
  input  logic             ms_bd,
  input  logic             int_pending,
  input  logic             cp0_status_ie,
  input  logic             cp0_status_exl,
  input  logic [DW-1:0]    cp0_rdata,
  output logic [CAW-1:0]   ws_cp0_addr,
  output logic             cp0_we,
  output logic [DW-1:0]    cp0_wdata,
  output logic             excp_commit,
  output logic [ECW-1:0]   excp_code,
  output logic [DW-1:0]    excp_pc,
  output logic             excp_bd,
  output logic             eret_commit,
  output logic             ws_flush,
  output logic             rf_we,
  output logic [RAW-1:0]   rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic             fw_valid,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [DW-1:0]    debug_wb_pc,
  output logic [DW/8-1:0]  debug_wb_rf_wen,
  output logic [RAW-1:0]   debug_wb_rf_wnum,
  output logic [DW-1:0]    debug_wb_rf_wdata
);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } rd_state_e;

  localparam bit PipeRd = (PIPE_CP0_READ != 0);

  rd_state_e        rd_state_q;
  logic             ready_q;
  logic [DW-1:0]    rdata_q;
  logic             ws_valid_q, ws_valid_d;
  logic [DW-1:0]    pc_q, result_q, rt_value_q;
  logic             gr_we_q, op_mfc0_q, op_mtc0_q, op_eret_q, excp_q, bd_q;
  logic [RAW-1:0]   dest_q;
  logic [CAW-1:0]   cp0_addr_q;
  logic [ECW-1:0]   excode_q;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic ws_ready_go, commit, int_take, exc_take, good, accept;

  assign ws_ready_go = ready_q;
  assign ws_allowin  = !ws_valid_q || ws_ready_go;
  assign accept      = ms_to_ws_valid && ws_allowin;
  assign commit      = ws_valid_q && ws_ready_go;

  // Interrupt outranks a synchronous exception, which outranks eret.
  assign int_take    = commit && int_pending && cp0_status_ie && !cp0_status_exl;
  assign exc_take    = commit && excp_q && !int_take;
  assign excp_commit = int_take || exc_take;
  assign excp_code   = int_take ? {ECW{1'b0}} : excode_q;
  assign excp_pc     = pc_q;
  assign excp_bd     = bd_q;
  assign eret_commit = commit && op_eret_q && !excp_commit;
  assign ws_flush    = excp_commit || eret_commit;
  assign good        = commit && !excp_commit;

  assign rf_we       = good && gr_we_q;
  assign rf_waddr    = dest_q;
  assign rf_wdata    = op_mfc0_q ? (PipeRd ? rdata_q : cp0_rdata) : result_q;
  assign cp0_we      = good && op_mtc0_q;
  assign cp0_wdata   = rt_value_q;
  assign ws_cp0_addr = cp0_addr_q;
  assign fw_valid    = ws_valid_q && gr_we_q;
  assign retire_cnt  = retire_cnt_q;

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {(DW/8){rf_we}};
  assign debug_wb_rf_wnum  = dest_q;
  assign debug_wb_rf_wdata = rf_wdata;

  always_comb begin
    ws_valid_d   = ws_valid_q;
    retire_cnt_d = retire_cnt_q;
    if (ws_flush) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
    end else begin
      ws_valid_d = ws_valid_q;
    end
    if (good) begin
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q   <= 1'b0;
      retire_cnt_q <= {CNT_W{1'b0}};
      pc_q         <= {DW{1'b0}};
      result_q     <= {DW{1'b0}};
      rt_value_q   <= {DW{1'b0}};
      gr_we_q      <= 1'b0;
      dest_q       <= {RAW{1'b0}};
      cp0_addr_q   <= {CAW{1'b0}};
      op_mfc0_q    <= 1'b0;
      op_mtc0_q    <= 1'b0;
      op_eret_q    <= 1'b0;
      excp_q       <= 1'b0;
      excode_q     <= {ECW{1'b0}};
      bd_q         <= 1'b0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      retire_cnt_q <= retire_cnt_d;
      if (accept) begin
        pc_q       <= ms_pc;
        result_q   <= ms_result;
        rt_value_q <= ms_rt_value;
        gr_we_q    <= ms_gr_we;
        dest_q     <= ms_dest;
        cp0_addr_q <= ms_cp0_addr;
        op_mfc0_q  <= ms_op_mfc0;
        op_mtc0_q  <= ms_op_mtc0;
        op_eret_q  <= ms_op_eret;
        excp_q     <= ms_excp;
        excode_q   <= ms_excode;
        bd_q       <= ms_bd;
      end
    end
  end

  // mfc0 read sequencer: one stall cycle while the CP0 read data is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      ready_q    <= 1'b1;
      rdata_q    <= {DW{1'b0}};
    end else if (PipeRd && accept && !ws_flush && ms_op_mfc0) begin
      rd_state_q <= RD_WAIT;
      ready_q    <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_WAIT: begin
          rd_state_q <= RD_DONE;
          ready_q    <= 1'b1;
          rdata_q    <= cp0_rdata;
        end
        RD_DONE: begin
          rd_state_q <= RD_IDLE;
          ready_q    <= 1'b1;
        end
        default: begin
          rd_state_q <= RD_IDLE;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed cycle table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_wb_commit_stage;
  localparam int DW = 32, RAW = 5, ECW = 5, CAW = 8, CNT_W = 8;
  localparam int OP_ALU = 0, OP_MFC0 = 1, OP_MTC0 = 2, OP_ERET = 3;
  localparam int NV = 21;

  typedef struct packed {
    logic [31:0] pc, result, rt;
    logic [7:0]  addr;
    logic [4:0]  dest, excode;
    logic        gr_we, mfc0, mtc0, eret, excp, bd;
  } ins_t;

  typedef struct {
    int   v, ip, ie, exl, rd;
    ins_t i;
    int   e_allow, e_rfwe, e_wdata, e_exc, e_code, e_eret, e_cpwe, e_cnt;
  } vec_t;

  typedef struct {
    logic        allowin, rf_we, cp0_we, exc, eret, flush, fw, bd;
    logic [4:0]  code, waddr;
    logic [31:0] wdata, epc, cwdata;
    logic [7:0]  caddr;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ms_to_ws_valid = 1'b0;
  ins_t cur = '0;
  logic int_pending = 1'b0, cp0_status_ie = 1'b0, cp0_status_exl = 1'b0;
  logic [31:0] cp0_rdata = 32'd0;

  logic ws_allowin, cp0_we, excp_commit, excp_bd, eret_commit, ws_flush, rf_we, fw_valid;
  logic [CAW-1:0] ws_cp0_addr;
  logic [DW-1:0] cp0_wdata, excp_pc, rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [ECW-1:0] excp_code;
  logic [RAW-1:0] rf_waddr, debug_wb_rf_wnum;
  logic [CNT_W-1:0] retire_cnt;
  logic [DW/8-1:0] debug_wb_rf_wen;

  always #5 clk = ~clk;

  wb_commit_stage #(.DW(DW), .RAW(RAW), .ECW(ECW), .CAW(CAW), .PIPE_CP0_READ(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(cur.pc), .ms_result(cur.result), .ms_gr_we(cur.gr_we), .ms_dest(cur.dest),
    .ms_rt_value(cur.rt), .ms_cp0_addr(cur.addr), .ms_op_mfc0(cur.mfc0), .ms_op_mtc0(cur.mtc0),
    .ms_op_eret(cur.eret), .ms_excp(cur.excp), .ms_excode(cur.excode), .ms_bd(cur.bd),
    .int_pending(int_pending), .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl),
    .cp0_rdata(cp0_rdata), .ws_cp0_addr(ws_cp0_addr), .cp0_we(cp0_we), .cp0_wdata(cp0_wdata),
    .excp_commit(excp_commit), .excp_code(excp_code), .excp_pc(excp_pc), .excp_bd(excp_bd),
    .eret_commit(eret_commit), .ws_flush(ws_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fw_valid(fw_valid), .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mkins(input int op, input int excp, input int code, input int res, input int gw);
    ins_t i;
    i = '0;
    i.result = 32'(res);
    i.pc     = 32'h8000_0000 | 32'(res);
    i.rt     = 32'h0000_0011;
    i.addr   = 8'h60;
    i.dest   = 5'd5;
    i.excode = 5'(code);
    i.gr_we  = 1'(gw);
    i.mfc0   = (op == OP_MFC0);
    i.mtc0   = (op == OP_MTC0);
    i.eret   = (op == OP_ERET);
    i.excp   = 1'(excp);
    i.bd     = 1'b1;
    return i;
  endfunction

  function automatic vec_t mkv(input int v, op, excp, code, res, gw, ip, ie, exl, rd,
                               ea, ew, ewd, ee, ec, er, ecw, ecnt);
    vec_t t;
    t.v = v; t.ip = ip; t.ie = ie; t.exl = exl; t.rd = rd;
    t.i = mkins(op, excp, code, res, gw);
    t.e_allow = ea; t.e_rfwe = ew; t.e_wdata = ewd; t.e_exc = ee; t.e_code = ec;
    t.e_eret = er; t.e_cpwe = ecw; t.e_cnt = ecnt;
    return t;
  endfunction

  // Reference model: what sits in WB, how many stall cycles remain, captured CP0 data.
  logic        m_valid = 1'b0;
  ins_t        m_ins = '0;
  int          m_wait = 0;
  logic [31:0] m_rdata = 32'd0;
  int          m_cnt = 0;

  function automatic exp_t model_out();
    exp_t e;
    logic commit, it, et;
    commit    = m_valid && (m_wait == 0);
    it        = commit && int_pending && cp0_status_ie && !cp0_status_exl;
    et        = commit && m_ins.excp && !it;
    e.exc     = it || et;
    e.code    = it ? 5'd0 : m_ins.excode;
    e.eret    = commit && m_ins.eret && !e.exc;
    e.flush   = e.exc || e.eret;
    e.allowin = !m_valid || (m_wait == 0);
    e.rf_we   = commit && !e.exc && m_ins.gr_we;
    e.cp0_we  = commit && !e.exc && m_ins.mtc0;
    e.wdata   = m_ins.mfc0 ? m_rdata : m_ins.result;
    e.fw      = m_valid && m_ins.gr_we;
    e.bd      = m_ins.bd;
    e.epc     = m_ins.pc;
    e.waddr   = m_ins.dest;
    e.caddr   = m_ins.addr;
    e.cwdata  = m_ins.rt;
    e.cnt     = m_cnt;
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    logic commit, acc;
    if (reset) begin
      m_valid = 1'b0; m_ins = '0; m_wait = 0; m_rdata = 32'd0; m_cnt = 0;
    end else begin
      commit = m_valid && (m_wait == 0);
      if (commit && !e.exc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (m_wait > 0) begin
        m_rdata = cp0_rdata;
        m_wait--;
      end
      acc = ms_to_ws_valid && e.allowin;
      if (acc) m_ins = cur;
      if (e.flush) m_valid = 1'b0;
      else if (e.allowin) m_valid = ms_to_ws_valid;
      if (acc && !e.flush && cur.mfc0) m_wait = 1;
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("allowin", 64'(ws_allowin), 64'(e.allowin));
    chk("rf_we", 64'(rf_we), 64'(e.rf_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
    chk("cp0_we", 64'(cp0_we), 64'(e.cp0_we));
    chk("cp0_wdata", 64'(cp0_wdata), 64'(e.cwdata));
    chk("cp0_addr", 64'(ws_cp0_addr), 64'(e.caddr));
    chk("excp_commit", 64'(excp_commit), 64'(e.exc));
    chk("excp_code", 64'(excp_code), 64'(e.code));
    chk("excp_pc", 64'(excp_pc), 64'(e.epc));
    chk("excp_bd", 64'(excp_bd), 64'(e.bd));
    chk("eret_commit", 64'(eret_commit), 64'(e.eret));
    chk("ws_flush", 64'(ws_flush), 64'(e.flush));
    chk("fw_valid", 64'(fw_valid), 64'(e.fw));
    chk("retire_cnt", 64'(retire_cnt), 64'(e.cnt));
    chk("dbg_pc", 64'(debug_wb_pc), 64'(e.epc));
    chk("dbg_wen", 64'(debug_wb_rf_wen), e.rf_we ? 64'hF : 64'h0);
    chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(e.waddr));
    chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(e.wdata));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ms_to_ws_valid = 1'b0; cur = '0;
    int_pending = 1'b0; cp0_status_ie = 1'b0; cp0_status_exl = 1'b0; cp0_rdata = 32'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[NV];
    exp_t e;
    //                 v op     ex code  res      gw ip ie exl rd        al we wdata    ex code er cw cnt
    tbl[0]  = mkv(1, OP_ALU,  0, 0,    'h1234, 1, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 0);
    tbl[1]  = mkv(1, OP_ALU,  0, 0,    'h1234, 1, 0, 0, 0, 0,        1, 1, 'h1234,  0, 0,    0, 0, 0);
    tbl[2]  = mkv(1, OP_ALU,  0, 0,    'h1234, 1, 0, 0, 0, 0,        1, 1, 'h1234,  0, 0,    0, 0, 1);
    tbl[3]  = mkv(1, OP_MFC0, 0, 0,    0,      1, 0, 0, 0, 'hCAFE,   1, 1, 'h1234,  0, 0,    0, 0, 2);
    tbl[4]  = mkv(1, OP_ALU,  0, 0,    'h5678, 1, 0, 0, 0, 'hCAFE,   0, 0, 0,       0, 0,    0, 0, 3);
    tbl[5]  = mkv(1, OP_ALU,  0, 0,    'h5678, 1, 0, 0, 0, 'hBEEF,   1, 1, 'hCAFE,  0, 0,    0, 0, 3);
    tbl[6]  = mkv(1, OP_ALU,  1, 'h0C, 'h9999, 1, 0, 0, 0, 0,        1, 1, 'h5678,  0, 0,    0, 0, 4);
    tbl[7]  = mkv(1, OP_ALU,  0, 0,    'h1111, 1, 0, 0, 0, 0,        1, 0, 0,       1, 'h0C, 0, 0, 5);
    tbl[8]  = mkv(0, OP_ALU,  0, 0,    0,      0, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 5);
    tbl[9]  = mkv(1, OP_ALU,  0, 0,    'h2222, 1, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 5);
    tbl[10] = mkv(0, OP_ALU,  0, 0,    0,      0, 1, 1, 0, 0,        1, 0, 0,       1, 0,    0, 0, 5);
    tbl[11] = mkv(1, OP_ALU,  0, 0,    'h3333, 1, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 5);
    tbl[12] = mkv(0, OP_ALU,  0, 0,    0,      0, 1, 1, 1, 0,        1, 1, 'h3333,  0, 0,    0, 0, 5);
    tbl[13] = mkv(1, OP_ERET, 0, 0,    0,      0, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 6);
    tbl[14] = mkv(1, OP_MTC0, 0, 0,    0,      0, 0, 0, 0, 0,        1, 0, 0,       0, 0,    1, 0, 6);
    tbl[15] = mkv(1, OP_MTC0, 0, 0,    0,      0, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 7);
    tbl[16] = mkv(1, OP_MTC0, 1, 'h05, 0,      0, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 1, 7);
    tbl[17] = mkv(0, OP_ALU,  0, 0,    0,      0, 0, 0, 0, 0,        1, 0, 0,       1, 'h05, 0, 0, 8);
    tbl[18] = mkv(1, OP_ALU,  1, 'h0C, 'h4444, 1, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 8);
    tbl[19] = mkv(0, OP_ALU,  0, 0,    0,      0, 1, 1, 0, 0,        1, 0, 0,       1, 0,    0, 0, 8);
    tbl[20] = mkv(0, OP_ALU,  0, 0,    0,      0, 0, 0, 0, 0,        1, 0, 0,       0, 0,    0, 0, 8);

    // Reset state
    do_reset();
    #1;
    chk("rst_allowin", 64'(ws_allowin), 64'h1);
    chk("rst_rf_we", 64'(rf_we), 64'h0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'h0);
    chk("rst_excp", 64'(excp_commit), 64'h0);
    chk("rst_eret", 64'(eret_commit), 64'h0);
    chk("rst_flush", 64'(ws_flush), 64'h0);
    chk("rst_cp0_we", 64'(cp0_we), 64'h0);
    chk("rst_cnt", 64'(retire_cnt), 64'h0);
    chk("rst_dbg_pc", 64'(debug_wb_pc), 64'h0);
    chk("rst_fw", 64'(fw_valid), 64'h0);

    // Directed cycle table
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      ms_to_ws_valid = 1'(tbl[k].v);
      cur = tbl[k].i;
      int_pending = 1'(tbl[k].ip);
      cp0_status_ie = 1'(tbl[k].ie);
      cp0_status_exl = 1'(tbl[k].exl);
      cp0_rdata = 32'(tbl[k].rd);
      #1;
      chk("t_allowin", 64'(ws_allowin), 64'(tbl[k].e_allow));
      chk("t_rf_we", 64'(rf_we), 64'(tbl[k].e_rfwe));
      if (tbl[k].e_rfwe != 0) chk("t_rf_wdata", 64'(rf_wdata), 64'(32'(tbl[k].e_wdata)));
      chk("t_excp", 64'(excp_commit), 64'(tbl[k].e_exc));
      if (tbl[k].e_exc != 0) chk("t_code", 64'(excp_code), 64'(tbl[k].e_code));
      chk("t_eret", 64'(eret_commit), 64'(tbl[k].e_eret));
      chk("t_flush", 64'(ws_flush), 64'((tbl[k].e_exc != 0) || (tbl[k].e_eret != 0)));
      chk("t_cp0_we", 64'(cp0_we), 64'(tbl[k].e_cpwe));
      if (tbl[k].e_cpwe != 0) chk("t_cp0_wdata", 64'(cp0_wdata), 64'h11);
      chk("t_cnt", 64'(retire_cnt), 64'(tbl[k].e_cnt));
    end

    // Exception carries pc/bd/code, then the stage is empty
    do_reset();
    @(negedge clk);
    ms_to_ws_valid = 1'b1;
    cur = mkins(OP_ALU, 1, 'h0C, 'h55, 1);
    cur.pc = 32'hBFC0_0100;
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    #1;
    chk("ex_commit", 64'(excp_commit), 64'h1);
    chk("ex_code", 64'(excp_code), 64'h0C);
    chk("ex_pc", 64'(excp_pc), 64'hBFC0_0100);
    chk("ex_bd", 64'(excp_bd), 64'h1);
    chk("ex_flush", 64'(ws_flush), 64'h1);
    chk("ex_rf_we", 64'(rf_we), 64'h0);
    chk("ex_fw", 64'(fw_valid), 64'h1);
    @(negedge clk);
    #1;
    chk("ex_after_commit", 64'(excp_commit), 64'h0);
    chk("ex_after_fw", 64'(fw_valid), 64'h0);
    chk("ex_after_cnt", 64'(retire_cnt), 64'h0);

    // Reset while an mfc0 is waiting on its CP0 read
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ms_to_ws_valid = 1'b1;
      cur = mkins(OP_ALU, 0, 0, 'h10 + k, 1);
    end
    @(negedge clk);
    cur = mkins(OP_MFC0, 0, 0, 0, 1);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rw_stalled", 64'(ws_allowin), 64'h0);
    chk("rw_cp0_addr", 64'(ws_cp0_addr), 64'h60);
    chk("rw_cnt_before", 64'(retire_cnt), 64'h3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_allowin", 64'(ws_allowin), 64'h1);
    chk("rw_rf_we", 64'(rf_we), 64'h0);
    chk("rw_cnt", 64'(retire_cnt), 64'h0);
    chk("rw_dbg_pc", 64'(debug_wb_pc), 64'h0);
    chk("rw_cp0_addr0", 64'(ws_cp0_addr), 64'h0);
    chk("rw_fw", 64'(fw_valid), 64'h0);
    ms_to_ws_valid = 1'b1;
    cur = mkins(OP_ALU, 0, 0, 'hABCD, 1);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    #1;
    chk("rw_idle_rf_we", 64'(rf_we), 64'h1);
    chk("rw_idle_wdata", 64'(rf_wdata), 64'hABCD);
    chk("rw_idle_allowin", 64'(ws_allowin), 64'h1);
    @(negedge clk);
    #1;
    chk("rw_idle_cnt", 64'(retire_cnt), 64'h1);

    // Back-to-back retirement until the counter wraps
    do_reset();
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      ms_to_ws_valid = 1'b1;
      cur = mkins(OP_ALU, 0, 0, 'h1234, 1);
      #1;
      chk("b2b_allowin", 64'(ws_allowin), 64'h1);
      if (k == 256 || k == 257) chk("wrap_cnt", 64'(retire_cnt), 64'((k - 1) % 256));
    end

    // Random traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      int r;
      @(negedge clk);
      reset = (n == 0) || ($urandom_range(0, 199) == 0);
      ms_to_ws_valid = ($urandom_range(0, 3) != 0);
      cur.pc = $urandom;
      cur.result = $urandom;
      cur.rt = $urandom;
      cur.addr = 8'($urandom_range(0, 255));
      cur.dest = 5'($urandom_range(0, 31));
      cur.excode = 5'($urandom_range(1, 31));
      cur.gr_we = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      cur.mfc0 = (r < 30);
      cur.mtc0 = (r >= 30 && r < 40);
      cur.eret = (r >= 40 && r < 46);
      cur.excp = ($urandom_range(0, 9) == 0);
      cur.bd = 1'($urandom_range(0, 1));
      int_pending = ($urandom_range(0, 7) == 0);
      cp0_status_ie = 1'($urandom_range(0, 1));
      cp0_status_exl = 1'($urandom_range(0, 1));
      cp0_rdata = $urandom;
      #1;
      e = model_out();
      if (n != 0) compare_all(e);
      model_step(e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
